// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds the opcode values the controller decodes, the FSM state type and
// the select/op codes that drive the datapath muxes and the ALU decoder.
package riscv_ctrl_pkg;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_HALT = 7'b1000100;

   // Binary-encoded 4-bit state; encodings 14 and 15 are unused
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JALR_ADR = 4'd10,
      S_JAL      = 4'd11,
      S_HALT     = 4'd12,
      S_ERROR    = 4'd13
   } state_t;

   // ALUOp to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALUSrcB
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ImmSrc
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format selector for the immediate extender.
// Ports:
//   op      in  7  instr[6:0]
//   imm_src out 2  00 I-type (also lw/jalr/default), 01 S, 10 B, 11 J
module imm_src_dec
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] imm_src
);

   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_SW:   imm_src = IMM_S;
         OP_BR:   imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core. Sequences the shared ALU,
// unified memory and register file over 3-5 cycles per instruction, with a
// memory-ready stall on FETCH/MEMREAD/MEMWRITE, a sticky HALT and an
// illegal-opcode ERROR trap.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   op         in  7             instr[6:0] from IR
//   mem_ready  in  1             memory finishes the access this cycle
//   PCUpdate, Branch, IRWrite,
//   MemWrite, RegWrite           write strobes (forced 0 in reset)
//   AdrSrc                       memory address select
//   ResultSrc, ALUSrcA, ALUSrcB  datapath mux selects
//   ALUOp                        to the ALU decoder
//   ImmSrc                       immediate format, from op
//   instr_done                   pulse in the last cycle of an instruction
//   halted, illegal              state is HALT / ERROR
module multicycle_ctrl_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_EN = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       instr_done,
   output logic       halted,
   output logic       illegal
);

   state_t state, state_next;
   logic   ready;

   logic pc_update_raw, branch_raw, ir_write_raw;
   logic mem_write_raw, reg_write_raw, done_raw;

   assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   imm_src_dec u_imm_src_dec (
      .op      (op),
      .imm_src (ImmSrc)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_FETCH;
      else          state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = S_ERROR;
      case (state)
         S_FETCH:    state_next = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTER;
               OP_I:         state_next = S_EXECUTEI;
               OP_BR:        state_next = S_BEQ;
               OP_JAL:       state_next = S_JAL;
               OP_JALR:      state_next = S_JALR_ADR;
               OP_HALT:      state_next = S_HALT;
               default:      state_next = S_ERROR;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      state_next = S_MEMREAD;
            else if (op == OP_SW) state_next = S_MEMWRITE;
            else                  state_next = S_ERROR;
         end
         S_MEMREAD:  state_next = ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: state_next = ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: state_next = S_ALUWB;
         S_EXECUTEI: state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BEQ:      state_next = S_FETCH;
         S_JALR_ADR: state_next = S_JAL;
         // JAL is reused by jalr: writes the target to PC, then ALUWB stores OldPC+4
         S_JAL:      state_next = S_ALUWB;
         S_HALT:     state_next = S_HALT;
         S_ERROR:    state_next = S_ERROR;
         default:    state_next = S_ERROR;
      endcase
   end

   // Output decode (Moore, except the mem_ready-gated strobes)
   always_comb begin
      pc_update_raw = 1'b0;
      branch_raw    = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      done_raw      = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_RS2;
      ALUOp         = ALUOP_ADD;
      halted        = 1'b0;
      illegal       = 1'b0;
      case (state)
         S_FETCH: begin
            ALUSrcB       = SRCB_FOUR;
            ResultSrc     = RES_ALURESULT;
            ir_write_raw  = ready;
            pc_update_raw = ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc     = RES_DATA;
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
            done_raw      = ready;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA    = SRCA_RS1;
            ALUOp      = ALUOP_BR;
            branch_raw = 1'b1;
            done_raw   = 1'b1;
         end
         S_JALR_ADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_JAL: begin
            ALUSrcA       = SRCA_OLDPC;
            ALUSrcB       = SRCB_FOUR;
            pc_update_raw = 1'b1;
         end
         S_HALT:  halted  = 1'b1;
         S_ERROR: illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
   end

   // State already sits in FETCH during reset; gating keeps FETCH strobes quiet
   assign PCUpdate   = reset_n & pc_update_raw;
   assign Branch     = reset_n & branch_raw;
   assign IRWrite    = reset_n & ir_write_raw;
   assign MemWrite   = reset_n & mem_write_raw;
   assign RegWrite   = reset_n & reg_write_raw;
   assign instr_done = reset_n & done_raw;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm. Each stimulus cycle pushes the
// hand-written expected output bundle; the monitor pops one per falling edge.
// Bundle bit order: PCUpdate,Branch,AdrSrc,IRWrite,MemWrite,RegWrite,
// ResultSrc[2],ALUSrcA[2],ALUSrcB[2],ALUOp[2],ImmSrc[2],instr_done,halted,illegal
module tb_multicycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] op;
   logic       mem_ready;
   logic       PCUpdate, Branch, AdrSrc, IRWrite, MemWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic       instr_done, halted, illegal;

   multicycle_ctrl_fsm #(.MEM_WAIT_EN(1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .mem_ready  (mem_ready),
      .PCUpdate   (PCUpdate),
      .Branch     (Branch),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .ImmSrc     (ImmSrc),
      .instr_done (instr_done),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0] v;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   logic [6:0] cur_op;
   logic [1:0] cur_imm;

   logic [18:0] E_RST, E_FETCH, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR_W, E_MWR_D;
   logic [18:0] E_EXR, E_EXI, E_ALUWB, E_BEQ, E_JADR, E_JAL, E_HALT, E_ERR;

   function automatic logic [18:0] mk(
      input logic pcu, input logic br, input logic adr, input logic irw,
      input logic mw, input logic rw, input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sbv, input logic [1:0] aop, input logic done,
      input logic h, input logic il);
      return {pcu, br, adr, irw, mw, rw, rs, sa, sbv, aop, 2'b00, done, h, il};
   endfunction

   // Drive one cycle of inputs just after the edge and queue its expectation
   task automatic step(input logic rn, input logic rdy, input logic [18:0] base,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n   = rn;
      mem_ready = rdy;
      op        = cur_op;
      e.v       = base | {14'b0, cur_imm, 3'b000};
      e.name    = nm;
      sb.push_back(e);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [18:0] act;
         e   = sb.pop_front();
         act = {PCUpdate, Branch, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, halted, illegal};
         compared++;
         if (act !== e.v) begin
            mismatched++;
            $display("FAIL %s: got %05h expected %05h", e.name, act, e.v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            pcu br adr irw mw rw rs     sa     sb     aop   done h il
      E_RST   = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
      E_FETCH = mk(1, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
      E_DEC   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0);
      E_MADR  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
      E_MRD   = mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      E_MWB   = mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      E_MWR_W = mk(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      E_MWR_D = mk(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      E_EXR   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0);
      E_EXI   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0);
      E_ALUWB = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      E_BEQ   = mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0, 0);
      E_JADR  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
      E_JAL   = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0);
      E_HALT  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
      E_ERR   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);

      reset_n   = 1'b0;
      mem_ready = 1'b1;
      cur_op    = 7'b0110011;
      cur_imm   = 2'b00;
      op        = cur_op;

      // Reset held 3 cycles with mem_ready=1: strobes stay low
      for (int i = 0; i < 3; i++) step(0, 1, E_RST, "reset_hold");

      // R-type, released straight into FETCH
      step(1, 1, E_FETCH, "r_fetch");
      step(1, 1, E_DEC,   "r_decode");
      step(1, 1, E_EXR,   "r_exec");
      step(1, 1, E_ALUWB, "r_aluwb");

      // lw with 2 stall cycles in MEMREAD: 7 cycles
      cur_op = 7'b0000011; cur_imm = 2'b00;
      step(1, 1, E_FETCH, "lw_fetch");
      step(1, 1, E_DEC,   "lw_decode");
      step(1, 1, E_MADR,  "lw_memadr");
      step(1, 0, E_MRD,   "lw_memread_w0");
      step(1, 0, E_MRD,   "lw_memread_w1");
      step(1, 1, E_MRD,   "lw_memread_ok");
      step(1, 1, E_MWB,   "lw_memwb");

      // sw with 3 stall cycles: MemWrite held 4 cycles
      cur_op = 7'b0100011; cur_imm = 2'b01;
      step(1, 1, E_FETCH, "sw_fetch");
      step(1, 1, E_DEC,   "sw_decode");
      step(1, 1, E_MADR,  "sw_memadr");
      for (int i = 0; i < 3; i++) step(1, 0, E_MWR_W, "sw_memwrite_wait");
      step(1, 1, E_MWR_D, "sw_memwrite_ok");

      // beq with a FETCH stall: no strobes while waiting
      cur_op = 7'b1100011; cur_imm = 2'b10;
      step(1, 0, E_RST,   "beq_fetch_wait");
      step(1, 1, E_FETCH, "beq_fetch");
      step(1, 1, E_DEC,   "beq_decode");
      step(1, 1, E_BEQ,   "beq_branch");

      // I-type with mem_ready low outside the memory states: ignored
      cur_op = 7'b0010011; cur_imm = 2'b00;
      step(1, 1, E_FETCH, "i_fetch");
      step(1, 0, E_DEC,   "i_decode");
      step(1, 0, E_EXI,   "i_exec");
      step(1, 0, E_ALUWB, "i_aluwb");

      // jalr: 5 cycles
      cur_op = 7'b1100111; cur_imm = 2'b00;
      step(1, 1, E_FETCH, "jalr_fetch");
      step(1, 1, E_DEC,   "jalr_decode");
      step(1, 1, E_JADR,  "jalr_adr");
      step(1, 1, E_JAL,   "jalr_jal");
      step(1, 1, E_ALUWB, "jalr_aluwb");

      // jal: 4 cycles
      cur_op = 7'b1101111; cur_imm = 2'b11;
      step(1, 1, E_FETCH, "jal_fetch");
      step(1, 1, E_DEC,   "jal_decode");
      step(1, 1, E_JAL,   "jal_jal");
      step(1, 1, E_ALUWB, "jal_aluwb");

      // halt: sticky for 20 cycles regardless of mem_ready
      cur_op = 7'b1000100; cur_imm = 2'b00;
      step(1, 1, E_FETCH, "halt_fetch");
      step(1, 1, E_DEC,   "halt_decode");
      for (int i = 0; i < 20; i++) begin
         logic r;
         r = (i % 2) == 0;
         step(1, r, E_HALT, "halt_hold");
      end
      step(0, 1, E_RST, "halt_reset");

      // illegal opcode traps
      cur_op = 7'b1111111; cur_imm = 2'b00;
      step(1, 1, E_FETCH, "ill_fetch");
      step(1, 1, E_DEC,   "ill_decode");
      for (int i = 0; i < 3; i++) step(1, 1, E_ERR, "ill_hold");
      step(0, 1, E_RST, "ill_reset");

      // reset mid R-type abandons the instruction
      cur_op = 7'b0110011; cur_imm = 2'b00;
      step(1, 1, E_FETCH, "rr_fetch");
      step(1, 1, E_DEC,   "rr_decode");
      step(1, 1, E_EXR,   "rr_exec");
      step(0, 1, E_RST,   "rr_reset");
      step(1, 1, E_FETCH, "rr2_fetch");
      step(1, 1, E_DEC,   "rr2_decode");
      step(1, 1, E_EXR,   "rr2_exec");
      step(1, 1, E_ALUWB, "rr2_aluwb");

      @(posedge clk);
      @(negedge clk);
      #1;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
